ark_run_ctrl: RTL and testbench

Parametrised run-control and fetch sequencer for the ARK processor family. It replaces the single-cycle fetch/start/halt/instruction-count logic with a multi-cycle fetch–execute state machine. The machine supports a wait-stated instruction memory handshake, absolute or PC-relative branching, restart at any time, and saturating instruction and cycle counters. It sits between the instruction memory and the decode/execute datapath inside the processor top level.

---
 rtl/ark_pkg.sv | 18 +
 rtl/ark_sat_counter.sv | 38 +++
 rtl/ark_run_ctrl.sv | 149 ++++++++++++++
 tb/tb_ark_run_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ark_pkg.sv
// Shared types and constants for the ARK run-control block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ark_pkg;

  // Run-control states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    EXEC   = 2'd2,
    HALTED = 2'd3
  } run_state_t;

  // Branch target interpretation.
  localparam int BR_ABS = 0;
  localparam int BR_REL = 1;

endpackage

// File: rtl/ark_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Latency: q updates one cycle after en/clr; clr wins over en.
// Backpressure: none; holds at all-ones instead of wrapping.
module ark_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next value: clear, increment unless already saturated, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/ark_run_ctrl.sv
// Fetch/execute run-control sequencer: fetch handshake, branch, halt, counters.
// Latency: >= 2 cycles per instruction (1 FETCH + 1 EXEC), +1 per imem wait state.
// Backpressure: FETCH holds imem_req/imem_addr until imem_ack; EXEC waits for exec_done.
module ark_run_ctrl
  import ark_pkg::*;
#(
  parameter int PC_W     = 8,
  parameter int INST_W   = 10,
  parameter int TGT_W    = 7,
  parameter int CNT_W    = 16,
  parameter int BR_MODE  = BR_ABS,
  parameter int START_PC = 0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              start,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_data,
  output logic [INST_W-1:0] inst,
  output logic              inst_valid,
  input  logic              exec_done,
  input  logic              branch,
  input  logic [TGT_W-1:0]  target,
  input  logic              halt_req,
  output logic [PC_W-1:0]   pc,
  output logic              halt,
  output logic [CNT_W-1:0]  inst_count,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam logic [PC_W-1:0] START_PC_V = PC_W'(START_PC);

  run_state_t          state_q;
  logic [PC_W-1:0]     pc_q;
  logic [PC_W-1:0]     pc_d;
  logic [INST_W-1:0]   inst_q;
  logic                inst_valid_q;
  logic                imem_req_q;
  logic                halt_q;

  logic signed [TGT_W-1:0] tgt_s;
  logic [PC_W-1:0]         br_pc;
  logic [PC_W-1:0]         seq_pc;

  logic inst_cnt_en;
  logic cyc_cnt_en;

  assign tgt_s = target;

  // Next PC for a completed non-halt instruction; wraps modulo 2^PC_W.
  always_comb begin
    seq_pc = pc_q + PC_W'(1);
    if (BR_MODE == BR_REL) begin
      br_pc = pc_q + PC_W'(tgt_s);
    end else begin
      br_pc = PC_W'(target);
    end
    pc_d = branch ? br_pc : seq_pc;
  end

  // Run-control FSM; start restarts from any state and abandons in-flight work.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      pc_q         <= START_PC_V;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      imem_req_q   <= 1'b0;
      halt_q       <= 1'b0;
    end else if (start) begin
      state_q      <= FETCH;
      pc_q         <= START_PC_V;
      inst_valid_q <= 1'b0;
      imem_req_q   <= 1'b1;
      halt_q       <= 1'b0;
    end else begin
      // inst_valid is a single-cycle pulse on EXEC entry.
      inst_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          state_q <= IDLE;
        end
        FETCH: begin
          if (imem_ack) begin
            inst_q       <= imem_data;
            inst_valid_q <= 1'b1;
            imem_req_q   <= 1'b0;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          if (exec_done) begin
            // Halt beats branch; pc is left pointing at the halt instruction.
            if (halt_req) begin
              state_q <= HALTED;
              halt_q  <= 1'b1;
            end else begin
              pc_q       <= pc_d;
              imem_req_q <= 1'b1;
              state_q    <= FETCH;
            end
          end
        end
        HALTED: begin
          state_q <= HALTED;
        end
        default: begin
          state_q    <= IDLE;
          imem_req_q <= 1'b0;
          halt_q     <= 1'b0;
        end
      endcase
    end
  end

  // Counters count only while running; start clears them and wins over counting.
  assign inst_cnt_en = (state_q == EXEC) && exec_done;
  assign cyc_cnt_en  = (state_q == FETCH) || (state_q == EXEC);

  ark_sat_counter #(
    .W (CNT_W)
  ) u_inst_cnt (
    .clk   (CLK),
    .rst_n (RST_N),
    .clr   (start),
    .en    (inst_cnt_en),
    .q     (inst_count)
  );

  ark_sat_counter #(
    .W (CNT_W)
  ) u_cycle_cnt (
    .clk   (CLK),
    .rst_n (RST_N),
    .clr   (start),
    .en    (cyc_cnt_en),
    .q     (cycle_count)
  );

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign halt       = halt_q;

endmodule

// File: tb/tb_ark_run_ctrl.sv
// Bench for ark_run_ctrl: two instances (absolute/16-bit counters and
// relative/4-bit counters) share one stimulus stream; a behavioural model
// tracks both.
module tb_ark_run_ctrl;

  localparam int PC_W   = 8;
  localparam int INST_W = 10;
  localparam int TGT_W  = 7;

  logic CLK = 1'b0;
  logic RST_N;
  logic start;
  logic imem_ack;
  logic [INST_W-1:0] imem_data;
  logic exec_done;
  logic branch;
  logic [TGT_W-1:0] target;
  logic halt_req;

  logic a_req, a_vld, a_halt;
  logic [PC_W-1:0] a_addr, a_pc;
  logic [INST_W-1:0] a_inst;
  logic [15:0] a_ic, a_cc;

  logic r_req, r_vld, r_halt;
  logic [PC_W-1:0] r_addr, r_pc;
  logic [INST_W-1:0] r_inst;
  logic [3:0] r_ic, r_cc;

  always #5 CLK = ~CLK;

  ark_run_ctrl #(
    .PC_W(PC_W), .INST_W(INST_W), .TGT_W(TGT_W), .CNT_W(16),
    .BR_MODE(ark_pkg::BR_ABS), .START_PC(0)
  ) u_abs (
    .CLK(CLK), .RST_N(RST_N), .start(start),
    .imem_req(a_req), .imem_addr(a_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .inst(a_inst), .inst_valid(a_vld), .exec_done(exec_done), .branch(branch),
    .target(target), .halt_req(halt_req), .pc(a_pc), .halt(a_halt),
    .inst_count(a_ic), .cycle_count(a_cc)
  );

  ark_run_ctrl #(
    .PC_W(PC_W), .INST_W(INST_W), .TGT_W(TGT_W), .CNT_W(4),
    .BR_MODE(ark_pkg::BR_REL), .START_PC(0)
  ) u_rel (
    .CLK(CLK), .RST_N(RST_N), .start(start),
    .imem_req(r_req), .imem_addr(r_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .inst(r_inst), .inst_valid(r_vld), .exec_done(exec_done), .branch(branch),
    .target(target), .halt_req(halt_req), .pc(r_pc), .halt(r_halt),
    .inst_count(r_ic), .cycle_count(r_cc)
  );

  int total = 0;
  int bad   = 0;

  // Model: 0 idle, 1 fetch, 2 exec, 3 halted. Counts are unbounded and
  // saturated only when compared.
  int m_st, m_pc_a, m_pc_r, m_inst, m_vld, m_ic, m_cc;

  typedef struct {
    int st, ack, data, done, br, tgt, hr;
    int pc, req, vld, hlt, inst, ic, cc;
  } vec_t;
  vec_t tbl[8];

  function automatic int sat(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int off;
    if (!RST_N) begin
      m_st = 0; m_pc_a = 0; m_pc_r = 0; m_inst = 0; m_vld = 0; m_ic = 0; m_cc = 0;
    end else if (start) begin
      m_st = 1; m_pc_a = 0; m_pc_r = 0; m_vld = 0; m_ic = 0; m_cc = 0;
    end else begin
      m_vld = 0;
      if (m_st == 1) begin
        m_cc++;
        if (imem_ack) begin
          m_inst = int'(imem_data); m_vld = 1; m_st = 2;
        end
      end else if (m_st == 2) begin
        m_cc++;
        if (exec_done) begin
          m_ic++;
          if (halt_req) begin
            m_st = 3;
          end else begin
            if (branch) begin
              off = (int'(target) >= 64) ? int'(target) - 128 : int'(target);
              m_pc_a = int'(target);
              m_pc_r = (m_pc_r + off + 256) % 256;
            end else begin
              m_pc_a = (m_pc_a + 1) % 256;
              m_pc_r = (m_pc_r + 1) % 256;
            end
            m_st = 1;
          end
        end
      end
    end
  endtask

  task automatic check_model();
    chk("abs_pc", a_pc, m_pc_a);
    chk("rel_pc", r_pc, m_pc_r);
    chk("abs_addr", a_addr, m_pc_a);
    chk("rel_addr", r_addr, m_pc_r);
    chk("abs_req", a_req, int'(m_st == 1));
    chk("rel_req", r_req, int'(m_st == 1));
    chk("abs_vld", a_vld, m_vld);
    chk("rel_vld", r_vld, m_vld);
    chk("abs_halt", a_halt, int'(m_st == 3));
    chk("rel_halt", r_halt, int'(m_st == 3));
    chk("abs_inst", a_inst, m_inst);
    chk("rel_inst", r_inst, m_inst);
    chk("abs_icnt", a_ic, sat(m_ic, 65535));
    chk("abs_ccnt", a_cc, sat(m_cc, 65535));
    chk("rel_icnt", r_ic, sat(m_ic, 15));
    chk("rel_ccnt", r_cc, sat(m_cc, 15));
  endtask

  task automatic drive(input int s, input int ack, input int data, input int done,
                       input int br, input int tgt, input int hr);
    start     = s[0];
    imem_ack  = ack[0];
    imem_data = INST_W'(data);
    exec_done = done[0];
    branch    = br[0];
    target    = TGT_W'(tgt);
    halt_req  = hr[0];
  endtask

  // One clock: model follows the edge, outputs sampled 1 time unit later.
  task automatic cyc();
    @(posedge CLK);
    model_step();
    #1;
    check_model();
  endtask

  // Zero-wait instruction: ack in FETCH, exec_done in the first EXEC cycle.
  task automatic run_instr(input int br, input int tgt, input int hr);
    drive(0, 1, $urandom_range(1023), 0, 0, 0, 0); cyc();
    drive(0, 0, 0, 1, br, tgt, hr); cyc();
  endtask

  initial begin
    // Zero-wait run, halt on third instruction (branch also set: halt wins).
    tbl[0] = '{1, 0, 0,     0, 0, 0,    0, 0, 1, 0, 0, 0,     0, 0};
    tbl[1] = '{0, 1, 'h101, 0, 0, 0,    0, 0, 0, 1, 0, 'h101, 0, 1};
    tbl[2] = '{0, 0, 0,     1, 0, 0,    0, 1, 1, 0, 0, 'h101, 1, 2};
    tbl[3] = '{0, 1, 'h202, 0, 0, 0,    0, 1, 0, 1, 0, 'h202, 1, 3};
    tbl[4] = '{0, 0, 0,     1, 0, 0,    0, 2, 1, 0, 0, 'h202, 2, 4};
    tbl[5] = '{0, 1, 'h303, 0, 0, 0,    0, 2, 0, 1, 0, 'h303, 2, 5};
    tbl[6] = '{0, 0, 0,     1, 1, 'h40, 1, 2, 0, 0, 1, 'h303, 3, 6};
    tbl[7] = '{0, 1, 'h3FF, 1, 1, 'h40, 1, 2, 0, 0, 1, 'h303, 3, 6};

    // Reset held two cycles with start asserted.
    RST_N = 1'b0;
    drive(1, 1, 'h155, 1, 1, 5, 0);
    cyc();
    cyc();
    chk("rst_pc", a_pc, 0);
    chk("rst_halt", a_halt, 0);
    chk("rst_req", a_req, 0);
    chk("rst_icnt", a_ic, 0);
    chk("rst_ccnt", a_cc, 0);
    RST_N = 1'b1;
    drive(0, 1, 'h155, 1, 0, 0, 0);
    cyc();
    chk("idle_req", a_req, 0);

    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].st, tbl[i].ack, tbl[i].data, tbl[i].done, tbl[i].br, tbl[i].tgt, tbl[i].hr);
      cyc();
      chk($sformatf("tbl%0d_pc", i), a_pc, tbl[i].pc);
      chk($sformatf("tbl%0d_addr", i), r_addr, tbl[i].pc);
      chk($sformatf("tbl%0d_req", i), a_req, tbl[i].req);
      chk($sformatf("tbl%0d_vld", i), a_vld, tbl[i].vld);
      chk($sformatf("tbl%0d_halt", i), r_halt, tbl[i].hlt);
      chk($sformatf("tbl%0d_inst", i), a_inst, tbl[i].inst);
      chk($sformatf("tbl%0d_icnt", i), a_ic, tbl[i].ic);
      chk($sformatf("tbl%0d_ccnt", i), a_cc, tbl[i].cc);
    end

    // Fetch with three wait states.
    drive(1, 0, 0, 0, 0, 0, 0); cyc();
    for (int w = 0; w < 3; w++) begin
      drive(0, 0, 'h2AA, 0, 0, 0, 0); cyc();
      chk("wait_addr", a_addr, 0);
      chk("wait_req", a_req, 1);
    end
    drive(0, 1, 'h1C3, 0, 0, 0, 0); cyc();
    chk("wait_ccnt", a_cc, 4);
    chk("wait_inst", a_inst, 'h1C3);
    chk("wait_vld", a_vld, 1);
    drive(0, 0, 0, 1, 0, 0, 0); cyc();

    // Branching: walk to pc=5, then relative/absolute branches and wrap.
    drive(1, 0, 0, 0, 0, 0, 0); cyc();
    for (int k = 0; k < 5; k++) run_instr(0, 0, 0);
    chk("pc5_rel", r_pc, 5);
    run_instr(1, 'h7E, 0);
    chk("br_rel_back2", r_pc, 3);
    chk("br_abs_7e", a_pc, 'h7E);
    run_instr(1, 'h7C, 0);
    chk("br_rel_to_ff", r_pc, 'hFF);
    run_instr(0, 0, 0);
    chk("seq_wrap", r_pc, 0);
    run_instr(1, 'h40, 0);
    chk("br_abs_40", a_pc, 'h40);

    // Restart in the middle of EXEC; late exec_done/imem_ack must be ignored.
    run_instr(0, 0, 0);
    drive(0, 1, 'h0F0, 0, 0, 0, 0); cyc();
    drive(1, 1, 'h333, 1, 1, 'h11, 0); cyc();
    chk("rs_pc", a_pc, 0);
    chk("rs_req", a_req, 1);
    chk("rs_vld", a_vld, 0);
    chk("rs_icnt", a_ic, 0);
    chk("rs_ccnt", a_cc, 0);
    drive(0, 0, 0, 1, 1, 'h11, 0); cyc();
    chk("late_done_pc", a_pc, 0);
    chk("late_done_icnt", a_ic, 0);
    drive(0, 1, 'h0AB, 0, 0, 0, 0); cyc();
    drive(0, 1, 'h3CD, 0, 0, 0, 0); cyc();
    chk("late_ack_inst", a_inst, 'h0AB);
    drive(0, 0, 0, 1, 0, 0, 0); cyc();

    // Saturation with 4-bit counters.
    drive(1, 0, 0, 0, 0, 0, 0); cyc();
    for (int k = 0; k < 20; k++) run_instr(0, 0, 0);
    chk("sat_icnt4", r_ic, 15);
    chk("sat_ccnt4", r_cc, 15);
    chk("sat_icnt16", a_ic, 20);
    chk("sat_ccnt16", a_cc, 40);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      RST_N = ($urandom_range(299) != 0);
      drive(int'($urandom_range(39) == 0), int'($urandom_range(1)),
            int'($urandom_range(1023)), int'($urandom_range(1)),
            int'($urandom_range(2) == 0), int'($urandom_range(127)),
            int'($urandom_range(7) == 0));
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
